// File: rtl/block_serial_array.sv
// Bit-serial array of 2-input/2-select logic cells, LANES bits per clock, with optional bit-to-bit ripple.
// Optional o0_par output (XOR of the final o0) when BLOCK_SERIAL_PARITY_EN is defined.

module block_serial_array_cell (
    input  logic i0,
    input  logic i1,
    input  logic s0,
    input  logic s1,
    input  logic chain,
    input  logic cin,
    output logic o0,
    output logic o1
);
    logic i0e, a, b, c;
    assign i0e = chain ? (i0 ^ cin) : i0;
    assign a   = s1 | i0e;
    assign b   = s0 & i1;
    assign c   = a ^ b;
    assign o0  = s0 ? (a | b) : c;
    assign o1  = s1 ? c : (a & b);
endmodule

module block_serial_array #(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             s0,
    input  logic             s1,
    input  logic             chain,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
`ifdef BLOCK_SERIAL_PARITY_EN
    output logic             o0_par,
`endif
    output logic             carry_out
);
    localparam int C  = WIDTH / LANES;
    localparam int CW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] op0, op1, acc0, acc1, nxt0, nxt1;
    logic             s0_r, s1_r, chain_r, carry;
    logic [CW-1:0]    cnt;
    logic [LANES:0]   cin;
    logic [LANES-1:0] g0, g1;
    logic             last, accept;

    assign cin[0] = carry;

    // Low LANES bits of the operand shift registers form the current group.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        block_serial_array_cell u_cell (
            .i0    (op0[l]),
            .i1    (op1[l]),
            .s0    (s0_r),
            .s1    (s1_r),
            .chain (chain_r),
            .cin   (cin[l]),
            .o0    (g0[l]),
            .o1    (g1[l])
        );
        assign cin[l+1] = g1[l];
    end

    // Results enter at the top and shift down, so group 0 ends at the LSBs.
    assign nxt0   = WIDTH'({g0, acc0} >> LANES);
    assign nxt1   = WIDTH'({g1, acc1} >> LANES);
    assign last   = (cnt == CW'(C - 1));
    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op0       <= '0;
            op1       <= '0;
            acc0      <= '0;
            acc1      <= '0;
            s0_r      <= 1'b0;
            s1_r      <= 1'b0;
            chain_r   <= 1'b0;
            carry     <= 1'b0;
            cnt       <= '0;
            o0        <= '0;
            o1        <= '0;
            carry_out <= 1'b0;
`ifdef BLOCK_SERIAL_PARITY_EN
            o0_par    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                op0     <= i0;
                op1     <= i1;
                s0_r    <= s0;
                s1_r    <= s1;
                chain_r <= chain;
                carry   <= 1'b0;
                cnt     <= '0;
            end else if (state == RUN) begin
                op0   <= op0 >> LANES;
                op1   <= op1 >> LANES;
                acc0  <= nxt0;
                acc1  <= nxt1;
                carry <= cin[LANES];
                cnt   <= cnt + 1'b1;
                if (last) begin
                    o0        <= nxt0;
                    o1        <= nxt1;
                    carry_out <= chain_r & cin[LANES];
`ifdef BLOCK_SERIAL_PARITY_EN
                    o0_par    <= ^nxt0;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_block_serial_array.sv
// Scoreboard bench for block_serial_array: LANES=1 main instance plus LANES=2/4/8 siblings on shared inputs.
module tb_block_serial_array;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic       s0 = 1'b0, s1 = 1'b0, chain = 1'b0;
    logic [7:0] i0 = '0, i1 = '0;
    logic       busy, done, co;
    logic [7:0] o0, o1;
    logic [2:0] a_busy, a_done, a_co;
    logic [2:0][7:0] a_o0, a_o1;
`ifdef BLOCK_SERIAL_PARITY_EN
    logic       par;
    logic [2:0] a_par;
`endif

    always #5 clk = ~clk;

    block_serial_array #(.WIDTH(8), .LANES(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .i0(i0), .i1(i1),
        .s0(s0), .s1(s1), .chain(chain), .busy(busy), .done(done),
        .o0(o0), .o1(o1),
`ifdef BLOCK_SERIAL_PARITY_EN
        .o0_par(par),
`endif
        .carry_out(co)
    );

    for (genvar g = 0; g < 3; g++) begin : g_aux
        block_serial_array #(.WIDTH(8), .LANES(2 << g)) u_aux (
            .clk(clk), .rst(rst), .start(start), .i0(i0), .i1(i1),
            .s0(s0), .s1(s1), .chain(chain), .busy(a_busy[g]), .done(a_done[g]),
            .o0(a_o0[g]), .o1(a_o1[g]),
`ifdef BLOCK_SERIAL_PARITY_EN
            .o0_par(a_par[g]),
`endif
            .carry_out(a_co[g])
        );
    end

    typedef struct packed {
        logic [7:0] o0;
        logic [7:0] o1;
        logic       co;
    } res_t;
    typedef struct {
        res_t r;
        int   dcyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0, n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Straight bit-by-bit evaluation of the cell equations with LSB-first ripple.
    function automatic res_t model(input logic [7:0] a0, b0, input logic ss0, ss1, ch);
        res_t r;
        logic cin, i0e, a, b, c;
        cin = 1'b0;
        r   = '0;
        for (int k = 0; k < 8; k++) begin
            i0e = ch ? (a0[k] ^ cin) : a0[k];
            a = ss1 | i0e;
            b = ss0 & b0[k];
            c = a ^ b;
            r.o0[k] = ss0 ? (a | b) : c;
            r.o1[k] = ss1 ? c : (a & b);
            cin = r.o1[k];
        end
        r.co = ch & cin;
        return r;
    endfunction

    task automatic push(input int dcyc);
        exp_t e;
        e.r    = model(i0, i1, s0, s1, chain);
        e.dcyc = dcyc;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) chk("spurious_done", 32'(done), 32'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cyc", cyc, e.dcyc);
                    chk("o0", 32'(o0), 32'(e.r.o0));
                    chk("o1", 32'(o1), 32'(e.r.o1));
                    chk("carry_out", 32'(co), 32'(e.r.co));
`ifdef BLOCK_SERIAL_PARITY_EN
                    chk("o0_par", 32'(par), 32'(^e.r.o0));
`endif
                end
            end else if (sb.size() > 0 && cyc > sb[0].dcyc) begin
                chk("done_missing", cyc, sb[0].dcyc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic op(input logic [7:0] a, b, input logic ss0, ss1, ch, input bit pulse_mid);
        int t0;
        @(posedge clk); #1;
        i0 = a; i1 = b; s0 = ss0; s1 = ss1; chain = ch; start = 1'b1;
        t0 = cyc;
        push(t0 + 1 + 8);
        @(posedge clk); #1;
        start = 1'b0;
        i0 = ~a; i1 = ~b; s0 = ~ss0; s1 = ~ss1; chain = ~ch;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'd1);
            if (pulse_mid && k == 3) begin
                start = 1'b1;
                i0 = 8'($urandom);
            end
            if (k == 4) start = 1'b0;
        end
        drain();
    endtask

    initial begin
        res_t ea;
        int   t0, da, db, cl;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_o0", 32'(o0), 32'd0);
        chk("rst_o1", 32'(o1), 32'd0);
        chk("rst_co", 32'(co), 32'd0);
        rst = 1'b0;

        op(8'hA5, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        op(8'hF0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
        op(8'h5A, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
        op(8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++)
            op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0);

        // Back-to-back: start held through the DONE cycle with new operands.
        @(posedge clk); #1;
        i0 = 8'h3C; i1 = 8'hC3; s0 = 1'b1; s1 = 1'b0; chain = 1'b0; start = 1'b1;
        t0 = cyc;
        ea = model(i0, i1, s0, s1, chain);
        da = t0 + 1 + 8;
        db = da + 1 + 8;
        push(da);
        @(posedge clk); #1;
        i0 = 8'h96; i1 = 8'h0F; s0 = 1'b1; s1 = 1'b1; chain = 1'b1;
        push(db);
        while (cyc < db) begin
            @(negedge clk);
            if (cyc > da && cyc < db) begin
                chk("hold_o0", 32'(o0), 32'(ea.o0));
                chk("hold_o1", 32'(o1), 32'(ea.o1));
                chk("b2b_busy", 32'(busy), 32'd1);
            end
            if (cyc == da + 1) start = 1'b0;
        end
        drain();

        // Reset during run cycle 3 discards the operation.
        @(posedge clk); #1;
        i0 = 8'h77; i1 = 8'h11; s0 = 1'b1; s1 = 1'b0; chain = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_o0", 32'(o0), 32'd0);
        chk("mid_rst_o1", 32'(o1), 32'd0);
        repeat (12) @(negedge clk);
        op(8'hF0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);

        // Chain mode on every lane count; sibling done arrives after 8/LANES cycles.
        @(posedge clk); #1;
        i0 = 8'hFF; i1 = 8'hFF; s0 = 1'b1; s1 = 1'b0; chain = 1'b1; start = 1'b1;
        t0 = cyc;
        push(t0 + 1 + 8);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                cl = 8 / (2 << g);
                chk("lane_done", 32'(a_done[g]), 32'(k == cl));
                if (k == cl) begin
                    chk("lane_o0", 32'(a_o0[g]), 32'h0FF);
                    chk("lane_o1", 32'(a_o1[g]), 32'h055);
                    chk("lane_co", 32'(a_co[g]), 32'd0);
`ifdef BLOCK_SERIAL_PARITY_EN
                    chk("lane_par", 32'(a_par[g]), 32'd0);
`endif
                end
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/block_serial_array.md
Name: block_serial_array

Overview:
- Parametrised, sequential successor to the 2-input/2-select logic cell.
- Applies the same per-bit cell function across WIDTH-bit operand vectors, LANES bits per clock, under a start/busy/done handshake.
- Adds a chain mode: each bit's O1 ripples into the next bit's I0, across lanes within a cycle and across cycles via a carry register.
- Serves as the datapath slice for wider select-controlled logic ops in the 2021_digital design.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of LANES.
- LANES, 1, bits processed per clock; C = WIDTH/LANES run cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- i0  input  WIDTH  operand I0 vector
- i1  input  WIDTH  operand I1 vector
- s0  input  1  select S0, captured at start
- s1  input  1  select S1, captured at start
- chain  input  1  enables bit-to-bit ripple, captured at start
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse
- o0  output  WIDTH  result O0 vector, registered
- o1  output  WIDTH  result O1 vector, registered
- carry_out  output  1  O1 of the MSB when chain=1, else 0; registered

Behaviour:
- Cell function for bit k, with cin the O1 of bit k-1 (0 for bit 0):
  - i0e = chain ? (i0[k] ^ cin) : i0[k]
  - a = s1 | i0e; b = s0 & i1[k]; c = a ^ b
  - o0[k] = s0 ? (a | b) : c
  - o1[k] = s1 ? c : (a & b)
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, o0=0, o1=0, carry_out=0; internal shift and carry registers cleared. Reset overrides all other inputs, including mid-RUN; a partial operation is discarded and no done pulse is produced.
- IDLE: start=1 captures i0, i1, s0, s1 and chain, clears the carry register to 0, and moves to RUN.
- RUN:
  - Processes lanes [LANES*j +: LANES] in run cycle j (j = 0..C-1), LSB group first.
  - Ripples cin combinationally through the lanes; the group's top O1 is registered into the carry register for cycle j+1.
  - start, input and select changes are ignored.
  - After C cycles, the edge ending cycle C-1 loads o0, o1 and carry_out and moves to DONE.
- DONE: lasts one cycle with done=1, busy=0. start=1 in this cycle is accepted, giving back-to-back operation with no IDLE gap. Otherwise the state returns to IDLE.
- Latency: for start sampled at edge N, busy=1 after edges N..N+C-1, and done=1 with valid outputs after edge N+C.
- Outputs o0, o1 and carry_out hold their last values until the next completion or reset. They never show partial results.
- Results are bit-identical for every legal LANES value given the same inputs.

Optional Feature:
- Macro: BLOCK_SERIAL_PARITY_EN.
- Defined: adds output port o0_par (1 bit), equal to the XOR-reduction of the final o0. It is loaded on the same edge as o0 and reset to 0.
- Undefined: the port and its logic are absent. All other behaviour is unchanged.

Test Plan:
- Mode {s0,s1}=00, chain=0, WIDTH=8, LANES=1, i0=0xA5, i1=0xFF, start at edge N -> busy high for 8 cycles; done pulse after edge N+8; o0=0xA5, o1=0x00, carry_out=0.
- Mode 10, chain=0, i0=0xF0, i1=0x3C -> o0=0xFC, o1=0x30. With BLOCK_SERIAL_PARITY_EN defined, o0_par=0.
- Mode 11, chain=0, i1=0x3C, any i0 -> o0=0xFF, o1=0xC3. Mode 01, any operands -> o0=0xFF, o1=0xFF.
- Mode 10, chain=1, i0=0xFF, i1=0xFF, repeated for LANES=1, 2, 4 and 8 -> every case gives o0=0xFF, o1=0x55, carry_out=0, with done after C=8, 4, 2 and 1 cycles respectively.
- Back-to-back: start held high through the done cycle with new operands -> second operation starts with no IDLE cycle; first results stay stable until the second done. start pulsed mid-RUN -> ignored.
- Reset: rst asserted in run cycle 3 -> next cycle has busy=0, done=0, o0=o1=0; no done pulse follows; a fresh start then completes normally.
